// File: rtl/lfsr_pkg.sv
// Shared constants, state type and a reference step function for the 16-bit LFSR.
package lfsr_pkg;

  localparam int          LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_SEED  = 16'hECEB;
  localparam logic [15:0] LFSR_TAPS  = 16'h002D;

  typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

  // Returns {next_state, out_bit} for one enabled step from the given state.
  function automatic logic [LFSR_WIDTH:0] lfsr_step(input lfsr_state_t state);
    logic fb;
    fb = ^(state & LFSR_TAPS);
    return {fb, state[LFSR_WIDTH-1:1], state[0]};
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational feedback: parity of the tapped state bits.
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] state,
  output logic             fb
);

  assign fb = ^(state & TAPS);

endmodule

// File: rtl/lfsr.sv
// Fibonacci LFSR: shifts right one bit per enabled clock, feedback enters the MSB.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED,
  parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rand_bit,
  output logic [WIDTH-1:0] shift_reg
);

  logic fb;

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .state (shift_reg),
    .fb    (fb)
  );

  // Single register stage; reset dominates the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= SEED;
      rand_bit  <= 1'b0;
    end else if (en) begin
      shift_reg <= {fb, shift_reg[WIDTH-1:1]};
      rand_bit  <= shift_reg[0];
    end
  end

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: directed vector table, async reset cases, and a full-period random run.
module tb_lfsr;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rand_bit;
  logic [15:0] shift_reg;

  int checks;
  int errors;

  lfsr dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rand_bit  (rand_bit),
    .shift_reg (shift_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] exp_reg;
    logic        exp_bit;
  } vec_t;

  // Model from the rules: parity of taps 0,2,3,5 enters bit 15 after a right shift.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int ones;
    ones = $countones(s & 16'h002D);
    return (s >> 1) + ((ones % 2 == 1) ? 16'h8000 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [15:0] act_reg, input logic act_bit,
                       input logic [15:0] exp_reg, input logic exp_bit);
    checks++;
    if (act_reg !== exp_reg || act_bit !== exp_bit) begin
      errors++;
      $display("FAIL %s: got shift_reg=%h rand_bit=%b, expected shift_reg=%h rand_bit=%b",
               name, act_reg, act_bit, exp_reg, exp_bit);
    end
  endtask

  vec_t vecs[15];
  logic [15:0] model;
  logic        model_bit;
  int          idle;
  int          cycles;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    en  = 1'b0;

    // Async reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1 check("reset_async_initial", shift_reg, rand_bit, 16'hECEB, 1'b0);

    vecs[0]  = '{1'b1, 1'b0, 16'hECEB, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'hECEB, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'hECEB, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'hECEB, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'hF675, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'hF675, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'hF675, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 16'hFB3A, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'hFB3A, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h7D9D, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h7D9D, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'hECEB, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'hF675, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 16'hFB3A, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 16'h7D9D, 1'b0};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      en  = vecs[i].en;
      @(posedge clk);
      #1 check($sformatf("vector_%0d", i), shift_reg, rand_bit, vecs[i].exp_reg, vecs[i].exp_bit);
    end

    // Mid-cycle async reset after three steps, then restart from the first step.
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_mid_cycle", shift_reg, rand_bit, 16'hECEB, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1 check("step_after_reset", shift_reg, rand_bit, 16'hF675, 1'b1);

    // Full period with random idle gaps.
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model     = 16'hECEB;
    model_bit = 1'b0;
    cycles    = 0;
    for (int i = 0; i < 65535; i++) begin
      idle = ($urandom_range(0, 31) == 0) ? $urandom_range(1, 3) : 0;
      for (int k = 0; k < idle; k++) begin
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        cycles++;
        #1 check("hold", shift_reg, rand_bit, model, model_bit);
      end
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      cycles++;
      model_bit = model[0];
      model     = ref_next(model);
      #1 check($sformatf("step_%0d", i), shift_reg, rand_bit, model, model_bit);
      if (shift_reg == 16'h0000) begin
        checks++;
        errors++;
        $display("FAIL zero_state: got shift_reg=%h at step %0d, expected nonzero", shift_reg, i);
      end
      if (errors > 20) break;
    end
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (shift_reg !== 16'hECEB) begin
      errors++;
      $display("FAIL period_end: got shift_reg=%h, expected shift_reg=ecebafter 65535 steps", shift_reg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
